step_pulse_gen: RTL and testbench

STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

---
 rtl/tr_pkg.sv | 13 +
 rtl/phase_timer.sv | 21 ++
 rtl/step_pulse_gen.sv | 141 ++++++++++++++
 tb/tb_step_pulse_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tr_pkg.sv
// Shared state encoding and default timing constants for the step pulse generator.
package tr_pkg;
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIR_WAIT = 2'd1,
    S_HIGH     = 2'd2,
    S_LOW      = 2'd3
  } state_t;

  localparam int unsigned TR_PULSE_HIGH = 50;
  localparam int unsigned TR_DIR_SETUP  = 250;
  localparam int unsigned TR_MIN_PERIOD = 100;
endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; o_term is high once the count reaches zero, so a load
// of N-1 on phase entry makes the phase last exactly N cycles.
module phase_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_term
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)              r_cnt <= '0;
    else if (i_load)      r_cnt <= i_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
  end

  assign o_term = (r_cnt == '0);
endmodule

// File: rtl/step_pulse_gen.sv
// STEP/DIR pulse generator: issues n_steps STEP pulses at a clamped period,
// with DIR setup on direction change and non-truncating abort on enable loss.
module step_pulse_gen
  import tr_pkg::*;
#(
  parameter int unsigned WIDTH_WORK = 16,
  parameter int unsigned PULSE_HIGH = TR_PULSE_HIGH,
  parameter int unsigned DIR_SETUP  = TR_DIR_SETUP,
  parameter int unsigned MIN_PERIOD = TR_MIN_PERIOD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  dir_req,
  input  logic [WIDTH_WORK:0]   n_steps,
  input  logic [WIDTH_WORK-1:0] period,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [WIDTH_WORK:0]   step_count,
  output logic                  drv_step,
  output logic                  drv_dir,
  output logic                  drv_enable
);
  localparam logic [WIDTH_WORK-1:0] LP_HIGH_LD = WIDTH_WORK'(PULSE_HIGH - 1);
  localparam logic [WIDTH_WORK-1:0] LP_DIR_LD  = WIDTH_WORK'(DIR_SETUP - 1);
  localparam logic [WIDTH_WORK-1:0] LP_MIN     = WIDTH_WORK'(MIN_PERIOD);
  localparam logic [WIDTH_WORK-1:0] LP_LOW_OFS = WIDTH_WORK'(PULSE_HIGH + 1);
  localparam logic [WIDTH_WORK:0]   LP_ONE     = (WIDTH_WORK+1)'(1);

  state_t                r_state, w_next;
  logic [WIDTH_WORK:0]   r_n_steps, r_step_count;
  logic [WIDTH_WORK-1:0] r_eff_period, w_eff, w_load_val;
  logic                  r_dir, r_step, r_enable, r_done, r_aborted, r_abort_pend;
  logic                  w_accept, w_load, w_inc, w_done, w_abort, w_term;

  phase_timer #(.W(WIDTH_WORK)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_term (w_term)
  );

  assign w_eff = (period < LP_MIN) ? LP_MIN : period;

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_inc      = 1'b0;
    w_done     = 1'b0;
    w_abort    = 1'b0;
    w_accept   = start && enable && (r_state == S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_accept && n_steps != '0) begin
          w_load = 1'b1;
          if (dir_req != r_dir) begin
            w_next     = S_DIR_WAIT;
            w_load_val = LP_DIR_LD;
          end else begin
            w_next     = S_HIGH;
            w_load_val = LP_HIGH_LD;
            w_inc      = 1'b1;
          end
        end else if (w_accept) begin
          w_done = 1'b1;
        end
      end
      S_DIR_WAIT: begin
        if (!enable) begin
          w_next = S_IDLE; w_done = 1'b1; w_abort = 1'b1;
        end else if (w_term) begin
          w_next = S_HIGH; w_load = 1'b1; w_load_val = LP_HIGH_LD; w_inc = 1'b1;
        end
      end
      S_HIGH: begin
        // Enable loss during HIGH is deferred so the pulse keeps its full width.
        if (w_term) begin
          if (r_abort_pend || !enable) begin
            w_next = S_IDLE; w_done = 1'b1; w_abort = 1'b1;
          end else begin
            w_next = S_LOW; w_load = 1'b1; w_load_val = r_eff_period - LP_LOW_OFS;
          end
        end
      end
      S_LOW: begin
        if (!enable) begin
          w_next = S_IDLE; w_done = 1'b1; w_abort = 1'b1;
        end else if (w_term) begin
          if (r_step_count == r_n_steps) begin
            w_next = S_IDLE; w_done = 1'b1;
          end else begin
            w_next = S_HIGH; w_load = 1'b1; w_load_val = LP_HIGH_LD; w_inc = 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_n_steps    <= '0;
      r_eff_period <= '0;
      r_step_count <= '0;
      r_dir        <= 1'b0;
      r_step       <= 1'b0;
      r_enable     <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_enable     <= enable;
      r_done       <= w_done;
      r_aborted    <= w_abort;
      r_step       <= (w_next == S_HIGH);
      r_abort_pend <= (r_state == S_HIGH && w_next == S_HIGH) ? (r_abort_pend | ~enable) : 1'b0;
      if (w_accept) begin
        r_n_steps    <= n_steps;
        r_eff_period <= w_eff;
        r_step_count <= w_inc ? LP_ONE : '0;
        if (n_steps != '0) r_dir <= dir_req;
      end else if (w_inc) begin
        r_step_count <= r_step_count + LP_ONE;
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign step_count = r_step_count;
  assign drv_step   = r_step;
  assign drv_dir    = r_dir;
  assign drv_enable = r_enable;
endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: expected STEP edges and done pulses are
// queued with their cycle stamps before each start and matched by a monitor.
module tb_step_pulse_gen;
  localparam int WW = 16;
  localparam logic [1:0] EV_RISE = 2'd0, EV_FALL = 2'd1, EV_DONE = 2'd2;

  logic          clk = 1'b0, rst = 1'b1, enable = 1'b0, start = 1'b0, dir_req = 1'b0;
  logic [WW:0]   n_steps = '0;
  logic [WW-1:0] period = '0;
  logic          busy, done, aborted, drv_step, drv_dir, drv_enable;
  logic [WW:0]   step_count;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] t;
    logic        ab;
    logic [WW:0] sc;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  logic prev_step = 1'b0;

  step_pulse_gen #(.WIDTH_WORK(WW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .dir_req(dir_req),
    .n_steps(n_steps), .period(period), .busy(busy), .done(done), .aborted(aborted),
    .step_count(step_count), .drv_step(drv_step), .drv_dir(drv_dir), .drv_enable(drv_enable)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cyc %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic check_ev(input ev_t o);
    ev_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL unexpected_event: observed kind=%0d t=%0d ab=%0b sc=%0d expected none",
             o.kind, o.t, o.ab, o.sc);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL event: observed kind=%0d t=%0d ab=%0b sc=%0d expected kind=%0d t=%0d ab=%0b sc=%0d",
               o.kind, o.t, o.ab, o.sc, e.kind, e.t, e.ab, e.sc);
      end
    end
  endtask

  // Output monitor: every STEP edge and done pulse must match the queue head.
  always @(negedge clk) begin
    ev_t o;
    if (drv_step !== prev_step) begin
      o.kind = drv_step ? EV_RISE : EV_FALL;
      o.t = cyc; o.ab = 1'b0; o.sc = '0;
      check_ev(o);
    end
    prev_step = drv_step;
    if (done === 1'b1) begin
      o.kind = EV_DONE; o.t = cyc; o.ab = aborted; o.sc = step_count;
      check_ev(o);
    end
  end

  task automatic push_ev(input logic [1:0] k, input int t, input logic ab, input int sc);
    ev_t e;
    e.kind = k; e.t = t; e.ab = ab; e.sc = (WW+1)'(sc);
    exp_q.push_back(e);
  endtask

  task automatic push_move(input int first, input int n, input int eff);
    for (int k = 0; k < n; k++) begin
      push_ev(EV_RISE, first + k*eff, 1'b0, 0);
      push_ev(EV_FALL, first + k*eff + 50, 1'b0, 0);
    end
    push_ev(EV_DONE, first + n*eff, 1'b0, n);
  endtask

  task automatic go(input logic d, input int n, input int p);
    dir_req = d; n_steps = (WW+1)'(n); period = WW'(p); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_step_count", step_count, 0);
    chk("rst_drv_step", drv_step, 0);
    chk("rst_drv_dir", drv_dir, 0);
    chk("rst_drv_enable", drv_enable, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("drv_enable_follow", drv_enable, 1);

    // start without enable is ignored
    enable = 1'b0;
    go(1'b0, 2, 200);
    chk("noen_busy", busy, 0);
    chk("noen_drv_enable", drv_enable, 0);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);

    // three steps, period 200, same direction
    t0 = cyc;
    push_move(t0 + 1, 3, 200);
    go(1'b0, 3, 200);
    chk("s3_busy", busy, 1);
    drain("s3_drain", 800);
    chk("s3_hold_count", step_count, 3);
    chk("s3_idle", busy, 0);

    // period below minimum is clamped
    t0 = cyc;
    push_move(t0 + 1, 2, 100);
    go(1'b0, 2, 20);
    drain("clamp_drain", 400);

    // zero-step move
    t0 = cyc;
    push_ev(EV_DONE, t0 + 1, 1'b0, 0);
    go(1'b0, 0, 200);
    chk("zero_busy", busy, 0);
    chk("zero_step", drv_step, 0);
    drain("zero_drain", 10);

    // start while busy is ignored
    t0 = cyc;
    push_move(t0 + 1, 2, 100);
    go(1'b0, 2, 100);
    wait_until(t0 + 60);
    go(1'b1, 5, 300);
    chk("busy_start_dir", drv_dir, 0);
    chk("busy_start_count", step_count, 1);
    chk("busy_start_busy", busy, 1);
    drain("busy_start_drain", 400);

    // enable drop in HIGH of step 2: full pulse, then aborted done
    t0 = cyc;
    push_ev(EV_RISE, t0 + 1, 1'b0, 0);
    push_ev(EV_FALL, t0 + 51, 1'b0, 0);
    push_ev(EV_RISE, t0 + 201, 1'b0, 0);
    push_ev(EV_FALL, t0 + 251, 1'b0, 0);
    push_ev(EV_DONE, t0 + 251, 1'b1, 2);
    go(1'b0, 5, 200);
    wait_until(t0 + 211);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_high_step", drv_step, 1);
    drain("abort_high_drain", 400);
    enable = 1'b1;
    @(negedge clk);

    // enable drop in LOW aborts next cycle
    t0 = cyc;
    push_ev(EV_RISE, t0 + 1, 1'b0, 0);
    push_ev(EV_FALL, t0 + 51, 1'b0, 0);
    push_ev(EV_DONE, t0 + 71, 1'b1, 1);
    go(1'b0, 3, 100);
    wait_until(t0 + 70);
    enable = 1'b0;
    drain("abort_low_drain", 200);
    enable = 1'b1;
    @(negedge clk);

    // direction change: DIR setup before first STEP
    t0 = cyc;
    push_ev(EV_RISE, t0 + 251, 1'b0, 0);
    push_ev(EV_FALL, t0 + 301, 1'b0, 0);
    push_ev(EV_DONE, t0 + 351, 1'b0, 1);
    chk("dir_before", drv_dir, 0);
    go(1'b1, 1, 100);
    chk("dir_after", drv_dir, 1);
    chk("dir_busy", busy, 1);
    chk("dir_no_step", drv_step, 0);
    drain("dir_drain", 500);

    // reset mid-LOW: immediate reset values, no done
    t0 = cyc;
    push_ev(EV_RISE, t0 + 1, 1'b0, 0);
    push_ev(EV_FALL, t0 + 51, 1'b0, 0);
    go(1'b1, 3, 200);
    wait_until(t0 + 80);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_aborted", aborted, 0);
    chk("mid_rst_count", step_count, 0);
    chk("mid_rst_step", drv_step, 0);
    chk("mid_rst_dir", drv_dir, 0);
    chk("mid_rst_enable", drv_enable, 0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("mid_rst_queue", exp_q.size(), 0);
    chk("mid_rst_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
